// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
// Shared definitions for the universal shift register:
//   - mode select codes applied while the serialiser is idle
//   - controller state encoding (IDLE / SHIFT)
//   - datapath select passed from the controller to the register mux
// -----------------------------------------------------------------------------
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SHR  = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_LOAD = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_ROL  = 3'd5;
    localparam logic [2:0] MODE_ASR  = 3'd6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // What the datapath register does at the next edge.
    typedef enum logic [1:0] {
        DP_MODE = 2'd0,   // apply the mode-selected operation
        DP_LOAD = 2'd1,   // capture par_in to begin serialisation
        DP_SER  = 2'd2    // serial right shift with sl fill
    } dp_sel_e;

endpackage

// File: rtl/shift_reg_ctl.sv
// -----------------------------------------------------------------------------
// shift_reg_ctl
// Serialiser controller: IDLE/SHIFT FSM, serial bit counter, busy and done.
// All state updates on the falling clock edge; reset is synchronous.
// Ports:
//   clk     in   clock (falling edge active)
//   reset   in   synchronous active-high reset
//   start   in   request serialisation, honoured only in IDLE
//   busy    out  serialiser active (registered)
//   done    out  one-cycle pulse after the final serial bit (registered)
//   dp_sel  out  datapath operation for the next edge
// -----------------------------------------------------------------------------
module shift_reg_ctl
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    start,
    output logic    busy,
    output logic    done,
    output dp_sel_e dp_sel
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dp_sel  = DP_MODE;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dp_sel  = DP_LOAD;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                dp_sel = DP_SER;
                cnt_d  = cnt_q - CNT_W'(1);
                // Last bit leaves this edge: drop busy and pulse done together.
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
// Parametrised universal shift register with a self-timed LSB-first
// serialiser. State updates on the falling clock edge; reset is synchronous.
// Ports:
//   clk      in   clock (falling edge active)
//   reset    in   synchronous active-high reset
//   sl       in   serial fill into the MSB on right shift / serialisation
//   sr       in   serial fill into the LSB on left shift
//   par_in   in   parallel load data [WIDTH]
//   mode     in   operation select, used only while idle [3]
//   start    in   begin serialising par_in, sampled only while idle
//   par_out  out  register contents [WIDTH], registered
//   ser_out  out  par_out[0]
//   busy     out  serialiser active
//   done     out  one-cycle pulse after the last serial bit
// -----------------------------------------------------------------------------
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sl,
    input  logic             sr,
    input  logic [WIDTH-1:0] par_in,
    input  logic [2:0]       mode,
    input  logic             start,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] par_q, par_d;
    dp_sel_e          dp_sel;

    shift_reg_ctl #(
        .WIDTH (WIDTH)
    ) u_ctl (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .dp_sel (dp_sel)
    );

    always_comb begin
        par_d = par_q;
        case (dp_sel)
            DP_LOAD: par_d = par_in;
            DP_SER:  par_d = {sl, par_q[WIDTH-1:1]};
            DP_MODE: begin
                case (mode)
                    MODE_HOLD: par_d = par_q;
                    MODE_SHR:  par_d = {sl, par_q[WIDTH-1:1]};
                    MODE_SHL:  par_d = {par_q[WIDTH-2:0], sr};
                    MODE_LOAD: par_d = par_in;
                    MODE_ROR:  par_d = {par_q[0], par_q[WIDTH-1:1]};
                    MODE_ROL:  par_d = {par_q[WIDTH-2:0], par_q[WIDTH-1]};
                    MODE_ASR:  par_d = {par_q[WIDTH-1], par_q[WIDTH-1:1]};
                    default:   par_d = par_q;   // reserved code holds
                endcase
            end
            default: par_d = par_q;
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            par_q <= '0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_out = par_q;
    assign ser_out = par_q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=8). Inputs are driven on the
// rising edge; the DUT acts on the falling edge; a monitor samples 1 time unit
// after each falling edge and compares against expectations queued by the
// stimulus side from a behavioural model.
module tb_shift_reg_univ;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sl = 1'b0;
    logic         sr = 1'b0;
    logic [W-1:0] par_in = '0;
    logic [2:0]   mode = 3'd0;
    logic         start = 1'b0;
    logic [W-1:0] par_out;
    logic         ser_out;
    logic         busy;
    logic         done;

    shift_reg_univ #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .sl      (sl),
        .sr      (sr),
        .par_in  (par_in),
        .mode    (mode),
        .start   (start),
        .par_out (par_out),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] par;
        logic         ser;
        logic         busy;
        logic         done;
    } obs_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: a word plus the number of serial bits still owed.
    int unsigned m_par  = 0;
    int          m_left = 0;
    bit          m_done = 0;

    task automatic model_step(input bit r, input bit st, input int md,
                              input bit fl, input bit fr, input int unsigned pin);
        int unsigned msb;
        msb = 1 << (W - 1);
        if (r) begin
            m_par = 0; m_left = 0; m_done = 0;
        end else if (m_left > 0) begin
            m_par  = (m_par / 2) + (fl ? msb : 0);
            m_left = m_left - 1;
            m_done = (m_left == 0);
        end else begin
            m_done = 0;
            if (st) begin
                m_par  = pin;
                m_left = W;
            end else begin
                case (md)
                    1: m_par = (m_par / 2) + (fl ? msb : 0);
                    2: m_par = ((m_par * 2) % (1 << W)) + (fr ? 1 : 0);
                    3: m_par = pin;
                    4: m_par = (m_par / 2) + ((m_par % 2) * msb);
                    5: m_par = ((m_par * 2) % (1 << W)) + (m_par / msb);
                    6: m_par = (m_par / 2) + (m_par & msb);
                    default: m_par = m_par;
                endcase
            end
        end
    endtask

    // One clock of stimulus; the expected post-edge state goes to the scoreboard.
    task automatic drive(input bit r, input bit st, input int md,
                         input bit fl, input bit fr, input int unsigned pin);
        obs_t e;
        @(posedge clk);
        reset  = r;
        start  = st;
        mode   = md[2:0];
        sl     = fl;
        sr     = fr;
        par_in = pin[W-1:0];
        model_step(r, st, md, fl, fr, pin);
        e.par  = m_par[W-1:0];
        e.ser  = m_par[0];
        e.busy = (m_left > 0);
        e.done = m_done;
        sb.push_back(e);
    endtask

    initial begin : monitor
        obs_t exp_o;
        obs_t act_o;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_o = sb.pop_front();
                act_o = {par_out, ser_out, busy, done};
                n_checks++;
                if (act_o !== exp_o) begin
                    n_fail++;
                    $display("FAIL cycle_state @%0t: got par=%h ser=%b busy=%b done=%b, want par=%h ser=%b busy=%b done=%b",
                             $time, act_o.par, act_o.ser, act_o.busy, act_o.done,
                             exp_o.par, exp_o.ser, exp_o.busy, exp_o.done);
                end
            end
        end
    end

    initial begin : stim
        int waited;
        // Reset
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 3, 1, 1, 8'hFF);
        // Mode operations on known contents
        drive(0, 0, 3, 0, 0, 8'h0F); drive(0, 0, 1, 1, 0, 0);
        drive(0, 0, 3, 0, 0, 8'h0F); drive(0, 0, 2, 0, 0, 0);
        drive(0, 0, 3, 0, 0, 8'h81); drive(0, 0, 4, 0, 0, 0);
        drive(0, 0, 3, 0, 0, 8'h81); drive(0, 0, 5, 0, 0, 0);
        drive(0, 0, 3, 0, 0, 8'h80); drive(0, 0, 6, 0, 0, 0);
        drive(0, 0, 3, 0, 0, 8'h5A); drive(0, 0, 7, 1, 1, 8'h00);
        drive(0, 0, 0, 1, 1, 8'h00);
        // Serialise 0xA5 with sl=0, mode wiggling while busy
        drive(0, 1, 0, 0, 0, 8'hA5);
        for (int i = 0; i < 10; i++) drive(0, 0, $urandom_range(0, 7), 0, 1, $urandom);
        // Load then start with mode=2 together: start wins
        drive(0, 0, 3, 0, 0, 8'hFF);
        drive(0, 1, 2, 1, 0, 8'h3C);
        for (int i = 0; i < 10; i++) drive(0, 0, 2, 1, 0, 0);
        // start held continuously: 0x01 then 0x80, start toggled while busy
        drive(0, 1, 0, 0, 0, 8'h01);
        for (int i = 0; i < 8; i++) drive(0, i % 2, 3, 0, 0, 8'h80);
        for (int i = 0; i < 11; i++) drive(0, 1, 3, 0, 0, 8'h80);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 0);
        // Reset after 3 shifts of a word; no done may follow
        drive(0, 1, 0, 1, 0, 8'hA5);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 0, 0);
        // Random traffic
        for (int i = 0; i < 600; i++)
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 255));
        // Drain the scoreboard with a bounded wait
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
